// File: rtl/lu_pkg.sv
// rtl/lu_pkg.sv - opcodes, op width and FSM encoding shared by the logic unit and its arbiter
package lu_pkg;

  localparam int LU_OP_W = 2;

  localparam logic [LU_OP_W-1:0] LU_NOT = 2'b00;
  localparam logic [LU_OP_W-1:0] LU_AND = 2'b01;
  localparam logic [LU_OP_W-1:0] LU_OR  = 2'b10;
  localparam logic [LU_OP_W-1:0] LU_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } lu_state_e;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational W-bit NOT/AND/OR/XOR unit
module logic_unit
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [LU_OP_W-1:0] op,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  output logic [W-1:0]       y
);

  always_comb begin
    y = '0;
    case (op)
      LU_NOT:  y = ~a;
      LU_AND:  y = a & b;
      LU_OR:   y = a | b;
      LU_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin sharing of one logic unit among N requesters
module logic_unit_arbiter
  import lu_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [LU_OP_W*N-1:0]  op,
  input  logic [W*N-1:0]        a,
  input  logic [W*N-1:0]        b,
  output logic                  busy,
  output logic [N-1:0]          done,
  output logic [W-1:0]          result,
  output logic [$clog2(N)-1:0]  owner
);

  localparam int IDW = $clog2(N);

  lu_state_e            state_q, state_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [LU_OP_W-1:0]   op_q, op_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [W-1:0]         result_q, result_d;
  logic [N-1:0]         done_q, done_d;
  logic [W-1:0]         lu_y;
  logic [IDW-1:0]       win;
  logic                 found;

  logic_unit #(.W(W)) u_logic_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (lu_y)
  );

  // Search starts just past the last grant, so a re-requesting owner ranks last.
  always_comb begin
    logic [IDW-1:0] idx;
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IDW'((int'(last_q) + i) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = win;
          op_d    = op[LU_OP_W*win +: LU_OP_W];
          a_d     = a[W*win +: W];
          b_d     = b[W*win +: W];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d        = lu_y;
        done_d[owner_q] = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IDW'(N - 1);
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign owner  = owner_q;

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares a single W-bit logic unit (NOT/AND/OR/XOR) among N requesters in the SPARC datapath practice area. A round-robin arbiter grants one requester at a time, latches its opcode and operands, sequences one compute cycle through the shared unit, and returns a registered result with a one-cycle done pulse to the granted requester. Requesters are the existing gate-level test units and any future ALU-side clients.

## Interface
- N, 4, number of requesters (≥2)
- W, 4, operand/result width
- IDW, $clog2(N), requester-ID width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester request level; held until that requester's done
- op  in  2*N  per-requester opcode, slice i = op[2i+1:2i]
- a  in  W*N  per-requester operand A, slice i = a[W*i+W-1:W*i]
- b  in  W*N  per-requester operand B, same slicing
- busy  out  1  high whenever state ≠ IDLE
- done  out  N  one-hot, one-cycle pulse to the requester whose result is on `result`
- result  out  W  registered result; valid only while done ≠ 0
- owner  out  IDW  ID of current/last granted requester

## Operation
- Opcodes: 00 NOT a (b ignored), 01 a AND b, 10 a OR b, 11 a XOR b.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if req ≠ 0, select winner = first set bit searching from (last_grant+1) mod N upward with wrap; latch op/a/b of winner, set owner → EXEC. If req = 0, stay.
  - EXEC: result ← logic_unit(op_q, a_q, b_q) → RESP.
  - RESP: done[owner] = 1 → IDLE; last_grant ← owner.
- Operands and opcode are captured only at grant; later changes on the winner's inputs are ignored.
- Requests from non-winners remain pending; no queueing beyond the req level.
- A requester still asserting req in the IDLE cycle after its done is treated as a new request, with lowest priority relative to the others.
- Reset values: state IDLE, done 0, result 0, owner 0, busy 0, last_grant N-1 (requester 0 wins first).
- Reset asserted mid-operation: aborts immediately, no done pulse, latched operands discarded, all outputs go to reset values asynchronously.
- result holds its value after RESP until the next EXEC overwrites it; consumers sample only on done.

## Timing
- Grant sampled on edge ending IDLE cycle t; EXEC at t+1; done and valid result at t+2; IDLE again at t+3.
- Fixed latency 2 cycles from sampled request to done; peak throughput one operation per 3 cycles.
- Requesters use registered req: they see done during cycle t+2 and deassert req on the edge ending it.
- busy high in cycles t+1 and t+2 only.
- done never has more than one bit set; owner stable from EXEC through RESP.
- Simultaneous requests: round-robin from last_grant+1; a requester waits at most N-1 grants.

## Structure
- Shared package `lu_pkg`: opcode constants (LU_NOT, LU_AND, LU_OR, LU_XOR), FSM state encoding (IDLE, EXEC, RESP), 2-bit op width.
- Sub-module `logic_unit`: purely combinational W-bit unit (op, a, b → y); instantiated once, also reusable standalone and replacing the ad-hoc not_gate in benches.
- Arbiter, FSM, operand latches and result register stay in `logic_unit_arbiter`.

## Test plan
- Single request: req=0001, op0=00, a0=4'b1010 → done=0001 at t+2, result=4'b0101, owner=0, busy high t+1..t+2.
- All ops: requester 2, a=4'b1100, b=4'b1010, op 01/10/11 → results 1000 / 1110 / 0110, each 3 cycles apart.
- Fair arbitration: req=1111 held continuously after reset → done order 0,1,2,3,0; each requester served once per 12 cycles.
- Operand capture: grant requester 1 with a=4'b0011, change a to 4'b1111 during EXEC, op=00 → result 4'b1100.
- Reset mid-op: assert rst during EXEC → done stays 0, result=0, busy=0 immediately; after release, pending req=0100 served first-search from requester 0 → owner=2.
- Idle hold: req=0000 for 20 cycles → busy=0, done=0, state stays IDLE, result unchanged.
